seq_signed_divider: RTL and testbench

- Multi-cycle signed divider; inverse companion to the team's 8x8 signed combinational multiplier.
- Takes a 2*DW-bit two's-complement dividend and a DW-bit two's-complement divisor.
- Returns a 2*DW-bit quotient and a DW-bit remainder using a start/done handshake.
- Uses one iteration per quotient bit (non-restoring magnitude core plus sign fix-up), so a 16/8 divide costs one small adder.

---
 rtl/seq_signed_divider.sv | 157 +++++++++++++++
 tb/tb_seq_signed_divider.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed divider: 2*DW-bit dividend by DW-bit divisor, truncating semantics.
// Non-restoring magnitude core; optional saturation of overflow/divide-by-zero via `DIV_SAT_EN.
module seq_signed_divider #(
   parameter int unsigned DW = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2*DW-1:0] dividend,
   input  logic [DW-1:0]   divisor,
   output logic            busy,
   output logic            done,
   output logic [2*DW-1:0] quotient,
   output logic [DW-1:0]   remainder,
   output logic            ovf,
   output logic            dz
);

   localparam int unsigned QW = 2 * DW;
   localparam int unsigned RW = DW + 2;
   localparam int unsigned CW = $clog2(QW);

   typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [RW-1:0]   r_q, r_d;
   logic [QW-1:0]   q_q, q_d;
   logic [DW:0]     d_q, d_d;
   logic            dvd_neg_q, dvd_neg_d;
   logic            quo_neg_q, quo_neg_d;
   logic            dz_pend_q, dz_pend_d;
   logic            ovf_pend_q, ovf_pend_d;
   logic [QW-1:0]   quotient_q, quotient_d;
   logic [DW-1:0]   remainder_q, remainder_d;
   logic            ovf_q, ovf_d;
   logic            dz_q, dz_d;

   logic [QW-1:0]   dvd_abs;
   logic [DW:0]     dvs_abs;
   logic [RW-1:0]   d_ext, r_shift, r_step, r_fin;
   logic [DW-1:0]   rem_mag;
   logic [QW-1:0]   quo_fix, quo_ovf, quo_dz;

   // |-2^(QW-1)| is exact as a QW-bit unsigned value; the divisor needs the extra bit.
   always_comb begin
      dvd_abs = dividend[QW-1] ? (~dividend + QW'(1)) : dividend;
      dvs_abs = divisor[DW-1] ? ({1'b0, ~divisor} + (DW+1)'(1)) : {1'b0, divisor};
      d_ext   = {1'b0, d_q};
      r_shift = {r_q[RW-2:0], q_q[QW-1]};
      r_step  = r_q[RW-1] ? (r_shift + d_ext) : (r_shift - d_ext);
      r_fin   = r_q[RW-1] ? (r_q + d_ext) : r_q;
      rem_mag = DW'(r_fin);
      quo_fix = quo_neg_q ? (~q_q + QW'(1)) : q_q;
`ifdef DIV_SAT_EN
      quo_ovf = {1'b0, {(QW-1){1'b1}}};
      quo_dz  = dvd_neg_q ? {1'b1, {(QW-1){1'b0}}} : {1'b0, {(QW-1){1'b1}}};
`else
      quo_ovf = quo_fix;
      quo_dz  = '1;
`endif
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      r_d         = r_q;
      q_d         = q_q;
      d_d         = d_q;
      dvd_neg_d   = dvd_neg_q;
      quo_neg_d   = quo_neg_q;
      dz_pend_d   = dz_pend_q;
      ovf_pend_d  = ovf_pend_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      ovf_d       = ovf_q;
      dz_d        = dz_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               dvd_neg_d  = dividend[QW-1];
               quo_neg_d  = dividend[QW-1] ^ divisor[DW-1];
               q_d        = dvd_abs;
               d_d        = dvs_abs;
               r_d        = '0;
               cnt_d      = CW'(QW - 1);
               dz_pend_d  = (divisor == '0);
               ovf_pend_d = (dividend == {1'b1, {(QW-1){1'b0}}}) && (divisor == '1);
               state_d    = (divisor == '0) ? StFix : StCalc;
            end
         end
         StCalc: begin
            // Partial remainder stays in (-d, d); quotient bits shift in behind dividend bits.
            r_d   = r_step;
            q_d   = {q_q[QW-2:0], ~r_step[RW-1]};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) state_d = StFix;
         end
         StFix: begin
            if (dz_pend_q) begin
               quotient_d  = quo_dz;
               remainder_d = '0;
               ovf_d       = 1'b0;
               dz_d        = 1'b1;
            end else begin
               quotient_d  = ovf_pend_q ? quo_ovf : quo_fix;
               remainder_d = dvd_neg_q ? (~rem_mag + DW'(1)) : rem_mag;
               ovf_d       = ovf_pend_q;
               dz_d        = 1'b0;
            end
            state_d = StDone;
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         r_q         <= '0;
         q_q         <= '0;
         d_q         <= '0;
         dvd_neg_q   <= 1'b0;
         quo_neg_q   <= 1'b0;
         dz_pend_q   <= 1'b0;
         ovf_pend_q  <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         ovf_q       <= 1'b0;
         dz_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         r_q         <= r_d;
         q_q         <= q_d;
         d_q         <= d_d;
         dvd_neg_q   <= dvd_neg_d;
         quo_neg_q   <= quo_neg_d;
         dz_pend_q   <= dz_pend_d;
         ovf_pend_q  <= ovf_pend_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         ovf_q       <= ovf_d;
         dz_q        <= dz_d;
      end
   end

   assign busy      = (state_q == StCalc) || (state_q == StFix);
   assign done      = (state_q == StDone);
   assign quotient  = quotient_q;
   assign remainder = remainder_q;
   assign ovf       = ovf_q;
   assign dz        = dz_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed bench for seq_signed_divider: hand-computed quotients, latency, handshake and reset.
module tb_seq_signed_divider;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] dividend;
   logic [7:0]  divisor;
   logic        busy, done, ovf, dz;
   logic [15:0] quotient;
   logic [7:0]  remainder;

   int n_pass  = 0;
   int n_total = 0;

`ifdef DIV_SAT_EN
   localparam logic [15:0] QOVF = 16'h7FFF;
   localparam logic [15:0] QDZP = 16'h7FFF;
   localparam logic [15:0] QDZN = 16'h8000;
`else
   localparam logic [15:0] QOVF = 16'h8000;
   localparam logic [15:0] QDZP = 16'hFFFF;
   localparam logic [15:0] QDZN = 16'hFFFF;
`endif

   seq_signed_divider #(.DW(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .ovf       (ovf),
      .dz        (dz)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drives one request that is accepted on the next rising edge, then scrambles the operands.
   task automatic issue(input logic [15:0] a, input logic [7:0] b);
      @(negedge clk);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk);
      #1;
      start    = 1'b0;
      dividend = ~a;
      divisor  = b + 8'd3;
   endtask

   // Counts falling edges after the accepting edge until done; poke re-pulses start mid-operation.
   task automatic wait_done(input string tag, input int exp_lat, input logic [15:0] eq,
                            input logic [7:0] er, input logic eovf, input logic edz,
                            input int poke);
      int   lat = 0;
      logic busy_ok = 1'b1;
      for (int i = 1; i <= 40 && lat == 0; i++) begin
         @(negedge clk);
         if (i == poke) begin
            start    = 1'b1;
            dividend = 16'h1234;
            divisor  = 8'h03;
         end
         if (poke != 0 && i == poke + 1) start = 1'b0;
         if (done) lat = i;
         else if (!busy) busy_ok = 1'b0;
      end
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_busy_window"}, busy_ok, 1'b1);
      check({tag, "_busy_at_done"}, busy, 1'b0);
      check({tag, "_q"}, quotient, eq);
      check({tag, "_r"}, remainder, er);
      check({tag, "_ovf"}, ovf, eovf);
      check({tag, "_dz"}, dz, edz);
      @(negedge clk);
      check({tag, "_done_pulse"}, done, 1'b0);
   endtask

   initial begin
      logic seen;
      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      #12;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_outs", {quotient, remainder, ovf, dz}, '0);
      @(negedge clk);
      rst_n = 1'b1;

      issue(16'h3F01, 8'h7F);
      wait_done("exact", 18, 16'h007F, 8'h00, 1'b0, 1'b0, 0);
      issue(16'hFFF9, 8'h02);
      wait_done("neg7_by_2", 18, 16'hFFFD, 8'hFF, 1'b0, 1'b0, 0);
      issue(16'h0007, 8'hFE);
      wait_done("7_by_neg2", 18, 16'hFFFD, 8'h01, 1'b0, 1'b0, 0);
      issue(16'h4000, 8'h80);
      check("hold_on_accept", quotient, 16'hFFFD);
      wait_done("pos_by_min", 18, 16'hFF80, 8'h00, 1'b0, 1'b0, 0);
      issue(16'h8000, 8'h80);
      wait_done("min_by_min", 18, 16'h0100, 8'h00, 1'b0, 1'b0, 0);
      issue(16'hFF38, 8'h80);
      wait_done("neg200_by_min", 18, 16'h0001, 8'hB8, 1'b0, 1'b0, 0);
      issue(16'h8000, 8'hFF);
      wait_done("overflow", 18, QOVF, 8'h00, 1'b1, 1'b0, 0);
      issue(16'h8000, 8'h01);
      wait_done("min_by_1", 18, 16'h8000, 8'h00, 1'b0, 1'b0, 0);
      issue(16'hFF85, 8'hFF);
      wait_done("neg123_by_neg1", 18, 16'h007B, 8'h00, 1'b0, 1'b0, 0);
      issue(16'h0000, 8'h05);
      wait_done("zero_dividend", 18, 16'h0000, 8'h00, 1'b0, 1'b0, 0);
      issue(16'h1234, 8'h00);
      wait_done("dz_pos", 2, QDZP, 8'h00, 1'b0, 1'b1, 0);
      issue(16'hFFFF, 8'h00);
      wait_done("dz_neg", 2, QDZN, 8'h00, 1'b0, 1'b1, 0);
      issue(16'h3F01, 8'h7F);
      wait_done("restart_ignored", 18, 16'h007F, 8'h00, 1'b0, 1'b0, 5);
      issue(16'h03E8, 8'h07);
      wait_done("1000_by_7", 18, 16'h008E, 8'h06, 1'b0, 1'b0, 0);

      issue(16'h3F01, 8'h7F);
      repeat (8) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_outs", {quotient, remainder, ovf, dz}, '0);
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check("abort_no_done", seen, 1'b0);
      rst_n = 1'b1;
      issue(16'h0064, 8'h0A);
      wait_done("after_reset", 18, 16'h000A, 8'h00, 1'b0, 1'b0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
